// File: rtl/mill_modif_frame_demod.sv
// ============================================================================
// Module      : mill_modif_frame_demod
// Description : ISO14443-A Modified Miller frame decoder (X/Y/Z classification,
//               SOF/EOF framing, one-bit look-behind, error detection).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mill_modif_frame_demod #(
    parameter int ETU_CLKS = 16,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       in_rst_n,
    input  logic       in_enable,
    input  logic [1:0] in_rate,
    input  logic       in_data,
    output logic       out_data,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eof,
    output logic       out_err,
    output logic       out_busy
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_RX           = 2'd1,
        ST_WAIT_CARRIER = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PV_NONE     = 3'd0,
        PV_SOF_PEND = 3'd1,
        PV_SOF      = 3'd2,
        PV_ZERO     = 3'd3,
        PV_ONE      = 3'd4
    } prev_t;

    state_t             r_state, w_state_nxt;
    prev_t              r_prev, w_prev_nxt;
    logic               r_sync1, r_sync2;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_pa, w_pa_nxt;
    logic               r_pb, w_pb_nxt;
    logic [1:0]         r_shift, w_shift_nxt;
    logic               r_pend_vld, w_pend_vld_nxt;
    logic               r_pend_bit, w_pend_bit_nxt;
    logic               r_data, w_data_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_sof, w_sof_nxt;
    logic               r_eof, w_eof_nxt;
    logic               r_err, w_err_nxt;
    logic               w_bit_en, w_bit_val;

    logic               w_s;
    logic [1:0]         w_rate_clamp;
    logic [CNT_W-1:0]   w_etu_last;
    logic [CNT_W-1:0]   w_half;
    logic               w_first_half;
    logic               w_pa_cur, w_pb_cur;
    logic               w_sym_x, w_sym_z;

    assign w_s          = r_sync2;
    assign w_rate_clamp = (in_rate == 2'd3) ? 2'd2 : in_rate;
    assign w_etu_last   = CNT_W'((ETU_CLKS >> r_shift) - 1);
    assign w_half       = CNT_W'(ETU_CLKS >> (r_shift + 2'd1));
    assign w_first_half = (r_cnt < w_half);
    // Pause flags including the sample being processed this cycle
    assign w_pa_cur     = r_pa | (w_first_half & ~w_s);
    assign w_pb_cur     = r_pb | (~w_first_half & ~w_s);
    assign w_sym_z      = w_pa_cur & ~w_pb_cur;
    assign w_sym_x      = ~w_pa_cur & w_pb_cur;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pa_nxt       = r_pa;
        w_pb_nxt       = r_pb;
        w_shift_nxt    = r_shift;
        w_prev_nxt     = r_prev;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_bit_nxt = r_pend_bit;
        w_data_nxt     = 1'b0;
        w_valid_nxt    = 1'b0;
        w_sof_nxt      = 1'b0;
        w_eof_nxt      = 1'b0;
        w_err_nxt      = 1'b0;
        w_bit_en       = 1'b0;
        w_bit_val      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_s) begin
                    w_state_nxt    = ST_RX;
                    w_cnt_nxt      = CNT_W'(1);
                    w_pa_nxt       = 1'b1;
                    w_pb_nxt       = 1'b0;
                    w_shift_nxt    = w_rate_clamp;
                    w_prev_nxt     = PV_SOF_PEND;
                    w_pend_vld_nxt = 1'b0;
                    w_pend_bit_nxt = 1'b0;
                end
            end

            ST_RX: begin
                if (r_cnt == w_etu_last) begin
                    w_cnt_nxt = '0;
                    w_pa_nxt  = 1'b0;
                    w_pb_nxt  = 1'b0;
                    if (w_pa_cur && w_pb_cur) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        case (r_prev)
                            PV_SOF_PEND: begin
                                if (w_sym_z) begin
                                    w_sof_nxt  = 1'b1;
                                    w_prev_nxt = PV_SOF;
                                end else begin
                                    w_err_nxt = 1'b1;
                                end
                            end
                            PV_SOF: begin
                                if (w_sym_x || w_sym_z) begin
                                    w_bit_en  = 1'b1;
                                    w_bit_val = w_sym_x;
                                end else begin
                                    w_err_nxt = 1'b1;
                                end
                            end
                            PV_ZERO: begin
                                if (w_sym_x || w_sym_z) begin
                                    w_bit_en  = 1'b1;
                                    w_bit_val = w_sym_x;
                                end else begin
                                    w_eof_nxt = 1'b1;
                                end
                            end
                            PV_ONE: begin
                                if (w_sym_z) begin
                                    w_err_nxt = 1'b1;
                                end else begin
                                    w_bit_en  = 1'b1;
                                    w_bit_val = w_sym_x;
                                end
                            end
                            default: w_err_nxt = 1'b1;
                        endcase
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_pa_nxt  = w_pa_cur;
                    w_pb_nxt  = w_pb_cur;
                end
            end

            ST_WAIT_CARRIER: begin
                if (!w_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == w_etu_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase

        // Look-behind: a new bit releases the previously held one
        if (w_bit_en) begin
            w_valid_nxt    = r_pend_vld;
            w_data_nxt     = r_pend_vld & r_pend_bit;
            w_pend_vld_nxt = 1'b1;
            w_pend_bit_nxt = w_bit_val;
            w_prev_nxt     = w_bit_val ? PV_ONE : PV_ZERO;
        end

        if (w_eof_nxt || w_err_nxt) begin
            w_pend_vld_nxt = 1'b0;
            w_pend_bit_nxt = 1'b0;
            w_prev_nxt     = PV_NONE;
            w_state_nxt    = w_eof_nxt ? ST_IDLE : ST_WAIT_CARRIER;
        end
    end

    always_ff @(posedge clk) begin
        if (!in_rst_n || !in_enable) begin
            r_state    <= ST_IDLE;
            r_prev     <= PV_NONE;
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_cnt      <= '0;
            r_pa       <= 1'b0;
            r_pb       <= 1'b0;
            r_shift    <= 2'd0;
            r_pend_vld <= 1'b0;
            r_pend_bit <= 1'b0;
            r_data     <= 1'b0;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_prev_nxt;
            r_sync1    <= in_data;
            r_sync2    <= r_sync1;
            r_cnt      <= w_cnt_nxt;
            r_pa       <= w_pa_nxt;
            r_pb       <= w_pb_nxt;
            r_shift    <= w_shift_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_bit <= w_pend_bit_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_sof      <= w_sof_nxt;
            r_eof      <= w_eof_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_sof   = r_sof;
    assign out_eof   = r_eof;
    assign out_err   = r_err;
    assign out_busy  = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mill_modif_frame_demod.sv
// ============================================================================
// Module      : tb_mill_modif_frame_demod
// Description : Scoreboard bench for the Modified Miller frame decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mill_modif_frame_demod;

    localparam int K_VALID = 0;
    localparam int K_SOF   = 1;
    localparam int K_EOF   = 2;
    localparam int K_ERR   = 3;

    logic       clk = 1'b0;
    logic       in_rst_n = 1'b0;
    logic       in_enable = 1'b1;
    logic [1:0] in_rate = 2'd0;
    logic       in_data = 1'b1;
    logic       out_data, out_valid, out_sof, out_eof, out_err, out_busy;
    logic [5:0] outs;

    assign outs = {out_busy, out_err, out_eof, out_sof, out_valid, out_data};

    always #5 clk = ~clk;

    mill_modif_frame_demod #(.ETU_CLKS(16), .CNT_W(4)) dut (
        .clk       (clk),
        .in_rst_n  (in_rst_n),
        .in_enable (in_enable),
        .in_rate   (in_rate),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_err   (out_err),
        .out_busy  (out_busy)
    );

    // gap = expected clocks since the previous strobe, 0 = not checked
    typedef struct {
        int kind;
        bit data;
        int gap;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_cyc = 0;

    task automatic expect_ev(input int kind, input bit data, input int gap);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk);
        in_data = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    // Z: pause at ETU start, X: pause at mid-ETU, Y: none, B: both (illegal)
    task automatic sym(input byte c, input int e);
        int   p;
        int   h;
        logic v;
        p = e / 4;
        h = e / 2;
        for (int i = 0; i < e; i++) begin
            v = 1'b1;
            if ((c == "Z" || c == "B") && i < p) v = 1'b0;
            if ((c == "X" || c == "B") && i >= h && i < h + p) v = 1'b0;
            drive_bit(v);
        end
    endtask

    task automatic frame(input string s, input int e);
        for (int i = 0; i < s.len(); i++) sym(s[i], e);
    endtask

    task automatic check_vec(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Monitor: pops one expectation per observed strobe
    always @(negedge clk) begin
        int   n;
        int   kind;
        ev_t  e;
        cyc++;
        n = int'(out_valid) + int'(out_sof) + int'(out_eof) + int'(out_err);
        if (n != 0) begin
            if (n > 1) begin
                checks++;
                errors++;
                $display("FAIL strobe_exclusive: got %0d strobes expected 1 at cycle %0d", n, cyc);
            end
            kind = out_valid ? K_VALID : out_sof ? K_SOF : out_eof ? K_EOF : K_ERR;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_strobe: got kind %0d data %b expected none at cycle %0d",
                         kind, out_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (kind != e.kind || (kind == K_VALID && out_data != e.data)) begin
                    errors++;
                    $display("FAIL strobe_kind: got kind %0d data %b expected kind %0d data %b at cycle %0d",
                             kind, out_data, e.kind, e.data, cyc);
                end
                if (e.gap != 0) begin
                    checks++;
                    if (cyc - last_cyc != e.gap) begin
                        errors++;
                        $display("FAIL strobe_gap: got %0d expected %0d at cycle %0d",
                                 cyc - last_cyc, e.gap, cyc);
                    end
                end
            end
            last_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        in_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_vec("reset_state", outs, 6'b0);
        in_rst_n = 1'b1;
        idle(5);
        check_vec("idle_after_reset", outs, 6'b0);

        // T1: SOF,1,0,1,0,EOF at 106 kb/s (last 0 before Y is the EOF zero)
        in_rate = 2'd0;
        expect_ev(K_SOF, 0, 0);
        expect_ev(K_VALID, 1, 32);
        expect_ev(K_VALID, 0, 16);
        expect_ev(K_VALID, 1, 16);
        expect_ev(K_VALID, 0, 16);
        expect_ev(K_EOF, 0, 16);
        frame("ZXYXYZY", 16);
        idle(40);
        check_vec("t1_back_idle", outs, 6'b0);

        // T2: same stream at 424 kb/s; rate change mid-frame must be ignored
        in_rate = 2'd2;
        expect_ev(K_SOF, 0, 0);
        expect_ev(K_VALID, 1, 8);
        expect_ev(K_VALID, 0, 4);
        expect_ev(K_VALID, 1, 4);
        expect_ev(K_VALID, 0, 4);
        expect_ev(K_EOF, 0, 4);
        sym("Z", 4);
        in_rate = 2'd0;
        frame("XYXYZY", 4);
        idle(20);

        // T3: SOF,0,0,EOF at 212 kb/s
        in_rate = 2'd1;
        expect_ev(K_SOF, 0, 0);
        expect_ev(K_VALID, 0, 16);
        expect_ev(K_EOF, 0, 8);
        frame("ZZZY", 8);
        idle(30);

        // T4: Z after 1 is a violation; then carrier must be clean for one ETU
        in_rate = 2'd0;
        expect_ev(K_SOF, 0, 0);
        expect_ev(K_ERR, 0, 32);
        frame("ZXZ", 16);
        idle(5);
        drive_bit(1'b0);
        for (int i = 0; i < 18; i++) drive_bit(1'b1);
        check_bit("t4_wait_15_ones", out_busy, 1'b1);
        drive_bit(1'b1);
        check_bit("t4_wait_16_ones", out_busy, 1'b0);
        idle(10);

        // T5: pauses in both halves (rate code 3 = 424), then SOF directly followed by Y
        in_rate = 2'd3;
        expect_ev(K_SOF, 0, 0);
        expect_ev(K_ERR, 0, 4);
        frame("ZB", 4);
        idle(20);
        in_rate = 2'd0;
        expect_ev(K_SOF, 0, 0);
        expect_ev(K_ERR, 0, 16);
        frame("ZY", 16);
        idle(40);
        check_vec("t5_back_idle", outs, 6'b0);

        // T6: in_enable drop mid-frame, then a clean frame
        expect_ev(K_SOF, 0, 0);
        expect_ev(K_VALID, 1, 32);
        expect_ev(K_VALID, 0, 16);
        frame("ZXYX", 16);
        idle(8);
        check_bit("t6_busy_before_drop", out_busy, 1'b1);
        @(negedge clk);
        in_enable = 1'b0;
        @(negedge clk);
        check_vec("t6_enable_clear", outs, 6'b0);
        in_enable = 1'b1;
        idle(20);
        expect_ev(K_SOF, 0, 0);
        expect_ev(K_VALID, 1, 32);
        expect_ev(K_VALID, 0, 16);
        expect_ev(K_EOF, 0, 16);
        frame("ZXYZY", 16);
        idle(40);

        // T6b: same with reset
        expect_ev(K_SOF, 0, 0);
        expect_ev(K_VALID, 1, 32);
        expect_ev(K_VALID, 0, 16);
        frame("ZXYX", 16);
        idle(8);
        check_bit("t6b_busy_before_reset", out_busy, 1'b1);
        @(negedge clk);
        in_rst_n = 1'b0;
        @(negedge clk);
        check_vec("t6b_reset_clear", outs, 6'b0);
        in_rst_n = 1'b1;
        idle(20);
        expect_ev(K_SOF, 0, 0);
        expect_ev(K_VALID, 1, 32);
        expect_ev(K_VALID, 0, 16);
        expect_ev(K_EOF, 0, 16);
        frame("ZXYZY", 16);
        idle(40);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_empty: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
